vram_arbiter: RTL

- Sits directly downstream of the fragment shader's VRAM port; arbitrates it against the display scanout fetcher for a single shared VRAM memory port.
- Both clients use the shader's native protocol:
  - The client holds sel/wr/addr/data/mask until a one-cycle ack.
  - The client drops sel on the clock edge after ack.
- Converts each granted access into a ready/valid memory transaction and returns read data to the requester.

---
 rtl/vram_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Shares a single VRAM memory port between the display scanout fetcher
//   (read-only) and the fragment shader. Both clients use a hold-until-ack
//   handshake: sel/wr/addr/data/mask stay put until a one-cycle ack, and
//   sel drops on the edge after the ack. Each granted access becomes one
//   ready/valid memory transaction; read data is returned to the requester.
//   Only one transaction is in flight at a time.
//
// Ports
//   clk, reset_i                 clock, synchronous active-high reset
//   disp_sel_i, disp_addr_i      display read request
//   disp_ack_o, disp_data_o      display ack pulse / read data
//   frag_sel_i, frag_wr_i,       shader request, write/read, address,
//   frag_addr_i, frag_data_i,    write data and nibble write mask
//   frag_mask_i
//   frag_ack_o, frag_data_o      shader ack pulse / read data
//   mem_req_o, mem_wr_o,         memory request (valid), write flag,
//   mem_addr_o, mem_data_o,      address, write data, nibble mask
//   mem_mask_o
//   mem_ready_i                  memory accepts the request this cycle
//   mem_rvalid_i, mem_rdata_i    in-order read data return
module vram_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 16,
    parameter int MASK_WIDTH      = 4,
    parameter int DISP_MAX_CONSEC = 4
) (
    input  logic                  clk,
    input  logic                  reset_i,
    input  logic                  disp_sel_i,
    input  logic [ADDR_WIDTH-1:0] disp_addr_i,
    output logic                  disp_ack_o,
    output logic [DATA_WIDTH-1:0] disp_data_o,
    input  logic                  frag_sel_i,
    input  logic                  frag_wr_i,
    input  logic [ADDR_WIDTH-1:0] frag_addr_i,
    input  logic [DATA_WIDTH-1:0] frag_data_i,
    input  logic [MASK_WIDTH-1:0] frag_mask_i,
    output logic                  frag_ack_o,
    output logic [DATA_WIDTH-1:0] frag_data_o,
    output logic                  mem_req_o,
    output logic                  mem_wr_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic [MASK_WIDTH-1:0] mem_mask_o,
    input  logic                  mem_ready_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int CNT_W = (DISP_MAX_CONSEC < 1) ? 1 : $clog2(DISP_MAX_CONSEC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DISP_MAX_CONSEC);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_READ,
        ACK
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             gnt_frag_q;   // client owning the in-flight access
    logic [CNT_W-1:0] disp_cnt_q;   // display grants while the shader waits
    logic             grant;
    logic             grant_frag;

    // Next-state and arbitration decode. Requests are looked at only in IDLE,
    // so a client changing its inputs mid-access has no effect.
    always_comb begin
        state_d    = state_q;
        grant      = 1'b0;
        grant_frag = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (disp_sel_i || frag_sel_i) begin
                    grant      = 1'b1;
                    // Display has priority until it has starved a waiting
                    // shader for DISP_MAX_CONSEC grants in a row.
                    grant_frag = frag_sel_i && (!disp_sel_i || (disp_cnt_q == CNT_MAX));
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ready_i) begin
                    state_d = mem_wr_o ? ACK : WAIT_READ;
                end
            end
            WAIT_READ: begin
                if (mem_rvalid_i) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q     <= IDLE;
            gnt_frag_q  <= 1'b0;
            disp_cnt_q  <= '0;
            mem_wr_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_data_o  <= '0;
            mem_mask_o  <= '1;
            disp_data_o <= '0;
            frag_data_o <= '0;
        end else begin
            state_q <= state_d;

            // A shader grant or an IDLE cycle without a waiting shader
            // restarts the starvation count.
            if (state_q == IDLE) begin
                if (grant_frag || !frag_sel_i) begin
                    disp_cnt_q <= '0;
                end else if (grant && (disp_cnt_q != CNT_MAX)) begin
                    disp_cnt_q <= disp_cnt_q + 1'b1;
                end
            end

            // The memory-side fields are latched once at grant and then held
            // for the whole ISSUE phase.
            if (grant) begin
                gnt_frag_q <= grant_frag;
                if (grant_frag) begin
                    mem_wr_o   <= frag_wr_i;
                    mem_addr_o <= frag_addr_i;
                    mem_data_o <= frag_data_i;
                    mem_mask_o <= frag_mask_i;
                end else begin
                    mem_wr_o   <= 1'b0;
                    mem_addr_o <= disp_addr_i;
                    mem_data_o <= '0;
                    mem_mask_o <= '1;
                end
            end

            // rvalid is meaningful only while a read is outstanding.
            if ((state_q == WAIT_READ) && mem_rvalid_i) begin
                if (gnt_frag_q) begin
                    frag_data_o <= mem_rdata_i;
                end else begin
                    disp_data_o <= mem_rdata_i;
                end
            end
        end
    end

    assign mem_req_o  = (state_q == ISSUE);
    assign disp_ack_o = (state_q == ACK) && !gnt_frag_q;
    assign frag_ack_o = (state_q == ACK) && gnt_frag_q;

endmodule
